// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Types and constants shared by the calculator core and its display driver.
//   status_t       : calculator status as reported by the core
//   conv_state_t   : states of the sequential binary-to-BCD converter
//   SEG_*          : active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a}
//   MAX_VAL        : largest value that fits on eight decimal digits
//   seg_of_bcd()   : BCD digit -> active-low segment pattern
// ---------------------------------------------------------------------------
package calc_pkg;

   typedef enum logic [1:0] {
      ERRO    = 2'd0,
      PRONTA  = 2'd1,
      OCUPADA = 2'd2
   } status_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CONV = 1'b1
   } conv_state_t;

   localparam logic [6:0]  SEG_BLANK = 7'h7F;
   localparam logic [6:0]  SEG_E     = 7'h06;
   localparam logic [6:0]  SEG_ZERO  = 7'h40;
   localparam logic [31:0] MAX_VAL   = 32'd99999999;

   function automatic logic [6:0] seg_of_bcd(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one input bit per clock.
//   clock  : system clock
//   reset  : asynchronous active-low reset
//   start  : convert `bin` (accepted only when idle)
//   bin    : binary input, VAL_W bits
//   busy   : high for exactly VAL_W cycles while converting
//   done   : high during the last conversion cycle (bcd updates on that edge)
//   bcd    : last converted result, NUM_DIGITS BCD nibbles, digit 0 in [3:0]
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import calc_pkg::*;
#(
   parameter int VAL_W      = 27,
   parameter int NUM_DIGITS = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [VAL_W-1:0]        bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(VAL_W + 1);

   conv_state_t        state_reg, state_next;
   logic [VAL_W-1:0]   bin_reg, bin_next;
   logic [BCD_W-1:0]   acc_reg, acc_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [BCD_W-1:0]   bcd_reg, bcd_next;

   logic [BCD_W-1:0]       acc_adj;
   logic [BCD_W+VAL_W-1:0] shifted;

   // Add-3 correction on every nibble before the shift.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                  acc_reg[4*gi +: 4] + 4'd3 : acc_reg[4*gi +: 4];
   end

   assign shifted = {acc_adj, bin_reg} << 1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         bin_reg   <= '0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         bcd_reg   <= '0;
      end else begin
         state_reg <= state_next;
         bin_reg   <= bin_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         bcd_reg   <= bcd_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      bin_next   = bin_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      bcd_next   = bcd_reg;
      done       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               bin_next   = bin;
               acc_next   = '0;
               cnt_next   = CNT_W'(VAL_W);
               state_next = ST_CONV;
            end
         end
         ST_CONV: begin
            {acc_next, bin_next} = shifted;
            cnt_next             = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               // Publish the fully shifted accumulator on the final edge.
               bcd_next   = shifted[BCD_W+VAL_W-1:VAL_W];
               done       = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign busy = (state_reg == ST_CONV);
   assign bcd  = bcd_reg;

endmodule

// File: rtl/calc_display_driver.sv
// ---------------------------------------------------------------------------
// calc_display_driver
// Drives a multiplexed 7-segment display from the calculator result.
//   clock  : system clock
//   reset  : asynchronous active-low reset
//   value  : binary result from the calculator core
//   status : calculator status (ERRO / PRONTA / OCUPADA; 3 treated as ERRO)
//   load   : one-cycle request to convert and latch `value`
//   busy   : conversion in progress
//   an     : active-low digit enables, bit 0 = rightmost digit
//   seg    : active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module calc_display_driver
   import calc_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int VAL_W       = 27,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [VAL_W-1:0]      value,
   input  logic [1:0]            status,
   input  logic                  load,
   output logic                  busy,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic                    conv_busy;
   logic                    conv_done;
   logic [4*NUM_DIGITS-1:0] disp_bcd;

   logic [VAL_W-1:0]      value_reg;
   logic                  overflow_reg;
   logic [REF_W-1:0]      ref_reg, ref_next;
   logic [IDX_W-1:0]      idx_reg, idx_next;
   logic [NUM_DIGITS-1:0] an_reg, an_next;
   logic [6:0]            seg_reg, seg_next;

   logic [31:0] value_ext;
   logic        show_err;
   logic        nz_seen;
   logic [6:0]  glyph [NUM_DIGITS];

   bin2bcd_seq #(
      .VAL_W      (VAL_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_conv (
      .clock (clock),
      .reset (reset),
      .start (load),
      .bin   (value),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (disp_bcd)
   );

   assign value_ext = 32'(value_reg);

   // Status codes other than PRONTA/OCUPADA (ERRO and the unused 3) show 'E'.
   assign show_err = overflow_reg ||
                     !((status == PRONTA) || (status == OCUPADA));

   // Leading-zero blanking: walk from the most significant digit down.
   always_comb begin
      nz_seen = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) glyph[k] = SEG_BLANK;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         if (show_err) begin
            glyph[k] = (k == 0) ? SEG_E : SEG_BLANK;
         end else begin
            nz_seen  = nz_seen || (disp_bcd[4*k +: 4] != 4'd0);
            glyph[k] = (k != 0 && !nz_seen) ? SEG_BLANK : seg_of_bcd(disp_bcd[4*k +: 4]);
         end
      end
   end

   always_comb begin
      ref_next = ref_reg + REF_W'(1);
      idx_next = idx_reg;
      if (ref_reg == REF_W'(REFRESH_DIV - 1)) begin
         ref_next = '0;
         idx_next = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end
      // an and seg are both derived from the next index so they switch together.
      an_next  = ~(NUM_DIGITS'(1) << idx_next);
      seg_next = glyph[idx_next];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         value_reg    <= '0;
         overflow_reg <= 1'b0;
         ref_reg      <= '0;
         idx_reg      <= '0;
         an_reg       <= ~NUM_DIGITS'(1);
         seg_reg      <= SEG_ZERO;
      end else begin
         // Same acceptance condition as the converter: loads during CONV are dropped.
         if (load && !conv_busy) value_reg <= value;
         if (conv_done) overflow_reg <= (value_ext > MAX_VAL);
         ref_reg <= ref_next;
         idx_reg <= idx_next;
         an_reg  <= an_next;
         seg_reg <= seg_next;
      end
   end

   assign busy = conv_busy;
   assign an   = an_reg;
   assign seg  = seg_reg;

endmodule

// File: doc/calc_display_driver.md
Name: calc_display_driver

Overview:
- Downstream stage of the calculator core: takes its binary result and status and drives an 8-digit multiplexed 7-segment display.
- Converts binary to BCD sequentially (double-dabble, one bit per cycle).
- Applies leading-zero blanking, an error glyph and overflow detection.
- Time-multiplexes the digit anodes with a programmable refresh divider.

Parameters:
- NUM_DIGITS, 8: number of display digits; anode width.
- VAL_W, 27: width of the binary input; 27 bits covers 99999999.
- REFRESH_DIV, 100000: clock cycles each digit stays enabled; must be >= 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- value  in  VAL_W  binary result from the calculator core.
- status  in  2  calculator status: 0 ERRO, 1 PRONTA, 2 OCUPADA.
- load  in  1  single-cycle request to convert and latch `value`.
- busy  out  1  high while a conversion is in progress.
- an  out  NUM_DIGITS  digit enables, active-low; bit 0 is the rightmost digit.
- seg  out  7  segments, active-low, order {g,f,e,d,c,b,a}.

Behaviour:
- Reset (asynchronous assert, synchronous release) clears:
  - FSM to IDLE, busy=0
  - BCD display register to 0, overflow flag to 0
  - scan index to 0, refresh counter to 0
- Reset output values: an=8'hFE, seg=7'h40 (digit 0 shows "0").
- FSM states:
  - IDLE: load=1 at edge N latches `value` into a shift register, clears the BCD accumulator and loads an iteration count of VAL_W. State is CONV from N+1.
  - CONV: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. After exactly VAL_W CONV cycles, write the result into the display register and return to IDLE.
  - busy=1 exactly while in CONV, i.e. VAL_W cycles. Display updates on the edge busy falls.
- load while in CONV is ignored; no queueing.
- Overflow: if the latched value > 99999999, set the overflow flag at the end of CONV. A later in-range conversion clears it.
- Display selection, evaluated in priority order each cycle:
  - status==ERRO or overflow: digit 0 shows 'E' (7'h06); all other digits blank (7'h7F).
  - Otherwise, status==OCUPADA: keep showing the current display register; load is still accepted.
  - Otherwise, decimal: digit 0 always shown; digit k>0 blanked if it and every higher digit are 0.
  - status==3: treated as ERRO.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances by 1, wrapping NUM_DIGITS-1 -> 0.
  - an = ~(1<<index); only one anode is active-low in any cycle.
- seg is registered together with an; both change on the same edge. No ghosting cycle.
- Digit encoding (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10, blank=7F, E=06.
- Reset mid-CONV aborts the conversion: busy=0 and the display returns to 0 immediately.

Decomposition:
- Package calc_pkg:
  - status enum {ERRO, PRONTA, OCUPADA}, shared with the calculator core.
  - Segment constants SEG_BLANK, SEG_E.
  - Function seg_of_bcd(4-bit) -> 7-bit.
  - Constant MAX_VAL = 99999999.
- Sub-module bin2bcd_seq:
  - Ports: clock, reset, start, bin[VAL_W], busy, done, bcd[4*NUM_DIGITS].
  - Contains the IDLE/CONV FSM and the iteration counter.
  - Top level holds the overflow flag, the blanking/selection logic and the scan counter.

Test Plan:
- Reset (REFRESH_DIV=4): release reset -> an=FE, seg=40, busy=0. an steps FE, FD, FB, ... 7F, FE, changing every 4 cycles.
- value=12345678, load pulse -> busy high for exactly 27 cycles. Then digit0 seg=00 ('8') and digit7 seg=79 ('1'); full scan reads 8,7,6,5,4,3,2,1.
- value=5, load -> digit0 seg=12; digits 1-7 seg=7F. Then value=1000, load -> digits 0-2 seg=40, digit3 seg=79, digits 4-7 seg=7F.
- value=100000000, load -> after busy falls, digit0 seg=06, others 7F. Then load value=7 -> digit0 seg=78 (overflow cleared).
- status=ERRO with a valid display loaded -> digit0=06, others 7F. status back to PRONTA -> prior digits reappear unchanged.
- Concurrency and reset: load 42, a second load 99 at busy cycle 5 -> the second is ignored and 42 is shown. Reset asserted at busy cycle 10 -> busy=0, an=FE, seg=40 asynchronously.
